// File: rtl/regfile_wb_pkg.sv
// Shared constants, types and helpers for the register-file writeback arbiter.
package regfile_wb_pkg;

  localparam int DATA_WIDTH    = 32;
  localparam int ADDRESS_WIDTH = 5;
  localparam logic [4:0] REG_ZERO = 5'd0;

  // One writeback request as seen by the register file write port.
  typedef struct packed {
    logic [ADDRESS_WIDTH-1:0] dest;
    logic [DATA_WIDTH-1:0]    data;
  } wb_req_t;

  // Round-robin successor: (ptr + 1) mod n, without a divider.
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
    if (ptr + 32'd1 >= n) begin
      return 32'd0;
    end else begin
      return ptr + 32'd1;
    end
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Purely combinational round-robin arbiter: rotates the request vector so
// that index ptr sits at bit 0, isolates the lowest set bit, and rotates the
// one-hot result back. ptr must be below N.
module rr_arbiter #(
  parameter int N     = 3,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant
);

  logic [N-1:0] req_rot;
  logic [N-1:0] gnt_rot;

  // Rotate, pick the first requester at or after ptr, rotate back.
  always_comb begin
    req_rot = N'({req, req} >> ptr);
    gnt_rot = req_rot & (~req_rot + N'(1));
    grant   = N'({gnt_rot, gnt_rot} << ptr >> N);
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter sharing the single register-file write port between
// NUM_REQ sources. Round-robin grant with valid/ready handshake, one-cycle
// registered issue stage, x0 write suppression and a saturating conflict
// counter.
// Optional feature: define REGFILE_WB_ARB_FWD_EN to add the decode bypass
// ports (fwd_rd_addr1/2, fwd_hit1/2, fwd_data).
module regfile_wb_arbiter
  import regfile_wb_pkg::*;
#(
  parameter int DATA_WIDTH    = regfile_wb_pkg::DATA_WIDTH,
  parameter int ADDRESS_WIDTH = regfile_wb_pkg::ADDRESS_WIDTH,
  parameter int NUM_REQ       = 3,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0]  req_dest,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_data,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic                              rg_wrt_en,
  output logic [ADDRESS_WIDTH-1:0]          rg_wrt_dest,
  output logic [DATA_WIDTH-1:0]             rg_wrt_data,
  output logic [CNT_WIDTH-1:0]              arb_conflict_cnt
`ifdef REGFILE_WB_ARB_FWD_EN
  ,
  input  logic [ADDRESS_WIDTH-1:0]          fwd_rd_addr1,
  input  logic [ADDRESS_WIDTH-1:0]          fwd_rd_addr2,
  output logic                              fwd_hit1,
  output logic                              fwd_hit2,
  output logic [DATA_WIDTH-1:0]             fwd_data
`endif
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic                     rg_wrt_en_q, rg_wrt_en_d;
  logic [ADDRESS_WIDTH-1:0] rg_wrt_dest_q, rg_wrt_dest_d;
  logic [DATA_WIDTH-1:0]    rg_wrt_data_q, rg_wrt_data_d;
  logic [CNT_WIDTH-1:0]     conflict_cnt_q, conflict_cnt_d;

  logic [NUM_REQ-1:0]       grant_s;
  logic                     handshake_s;
  logic                     conflict_s;
  logic [PTR_W-1:0]         win_idx_s;
  logic [ADDRESS_WIDTH-1:0] win_dest_s;
  logic [DATA_WIDTH-1:0]    win_data_s;

  rr_arbiter #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_rr_arbiter (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .grant (grant_s)
  );

  // Grant is masked during reset so nothing handshakes while the block is held.
  always_comb begin
    req_ready   = rst ? '0 : grant_s;
    handshake_s = |req_ready;
    conflict_s  = ($countones(req_valid) >= 32'd2);
  end

  // One-hot mux of the winner's index, destination and data.
  always_comb begin
    win_idx_s  = '0;
    win_dest_s = '0;
    win_data_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      win_idx_s  = win_idx_s  | (req_ready[i] ? PTR_W'(i) : '0);
      win_dest_s = win_dest_s | (req_ready[i] ? req_dest[i*ADDRESS_WIDTH +: ADDRESS_WIDTH] : '0);
      win_data_s = win_data_s | (req_ready[i] ? req_data[i*DATA_WIDTH +: DATA_WIDTH] : '0);
    end
  end

  // Next state: pointer advance, issue-stage load and saturating counter.
  always_comb begin
    rr_ptr_d       = rr_ptr_q;
    rg_wrt_en_d    = 1'b0;
    rg_wrt_dest_d  = rg_wrt_dest_q;
    rg_wrt_data_d  = rg_wrt_data_q;
    conflict_cnt_d = conflict_cnt_q;
    if (handshake_s) begin
      rr_ptr_d      = PTR_W'(rr_next(32'(win_idx_s), NUM_REQ));
      rg_wrt_en_d   = (win_dest_s != ADDRESS_WIDTH'(REG_ZERO));
      rg_wrt_dest_d = win_dest_s;
      rg_wrt_data_d = win_data_s;
    end else begin
      rg_wrt_en_d   = 1'b0;
    end
    if (conflict_s && (conflict_cnt_q != '1)) begin
      conflict_cnt_d = conflict_cnt_q + CNT_WIDTH'(1);
    end else begin
      conflict_cnt_d = conflict_cnt_q;
    end
  end

  // State registers with synchronous reset; a write accepted under reset is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q       <= '0;
      rg_wrt_en_q    <= 1'b0;
      rg_wrt_dest_q  <= '0;
      rg_wrt_data_q  <= '0;
      conflict_cnt_q <= '0;
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      rg_wrt_en_q    <= rg_wrt_en_d;
      rg_wrt_dest_q  <= rg_wrt_dest_d;
      rg_wrt_data_q  <= rg_wrt_data_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign rg_wrt_en        = rg_wrt_en_q;
  assign rg_wrt_dest      = rg_wrt_dest_q;
  assign rg_wrt_data      = rg_wrt_data_q;
  assign arb_conflict_cnt = conflict_cnt_q;

`ifdef REGFILE_WB_ARB_FWD_EN
  // Bypass a write that is issued but not yet captured by the register file.
  always_comb begin
    fwd_hit1 = rg_wrt_en_q && (rg_wrt_dest_q == fwd_rd_addr1)
               && (fwd_rd_addr1 != ADDRESS_WIDTH'(REG_ZERO));
    fwd_hit2 = rg_wrt_en_q && (rg_wrt_dest_q == fwd_rd_addr2)
               && (fwd_rd_addr2 != ADDRESS_WIDTH'(REG_ZERO));
    fwd_data = rg_wrt_data_q;
  end
`endif

endmodule
